// File: rtl/mvprod_pkg.sv
// Shared state type and arithmetic helpers for the matrix-vector product engine.
package mvprod_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } mvprod_state_t;

    localparam int SatWidth = 64;

    function automatic int acc_bits(input int nbits, input int len);
        return 2 * nbits + $clog2(len);
    endfunction

    // Arithmetic (floor) shift, then clamp to the signed range of nbits.
    function automatic logic signed [SatWidth-1:0] sat_shift(
        input logic signed [SatWidth-1:0] acc,
        input int                         shift,
        input int                         nbits
    );
        logic signed [SatWidth-1:0] shifted;
        logic signed [SatWidth-1:0] max_val;
        logic signed [SatWidth-1:0] min_val;
        shifted = acc >>> shift;
        max_val = (64'sd1 <<< (nbits - 1)) - 64'sd1;
        min_val = -max_val - 64'sd1;
        if (shifted > max_val)
            return max_val;
        else if (shifted < min_val)
            return min_val;
        else
            return shifted;
    endfunction

endpackage

// File: rtl/mvprod_engine_dot_chunk.sv
// Registered WorkingRegs-wide signed multiply and adder tree, one cycle of latency.
module dot_chunk #(
    parameter int WorkingRegs = 4,
    parameter int NBits       = 8,
    parameter int AccBits     = 18
) (
    input  logic                                 clk_in,
    input  logic                                 rst_in,
    input  logic signed [WorkingRegs-1:0][NBits-1:0] vec_a,
    input  logic signed [WorkingRegs-1:0][NBits-1:0] vec_b,
    output logic signed [AccBits-1:0]            sum
);

    logic signed [AccBits-1:0] sum_c;

    // Operands are sign-extended to the full accumulator width before multiplying.
    always_comb begin
        sum_c = '0;
        for (int i = 0; i < WorkingRegs; i++)
            sum_c = sum_c + AccBits'($signed(vec_a[i])) * AccBits'($signed(vec_b[i]));
    end

    always_ff @(posedge clk_in) begin
        if (rst_in)
            sum <= '0;
        else
            sum <= sum_c;
    end

endmodule

// File: rtl/mvprod_engine.sv
// Matrix-vector product engine: re-reads one staged vector per output row and emits saturated dot products.
module mvprod_engine
    import mvprod_pkg::*;
#(
    parameter int InVecLength  = 16,
    parameter int OutVecLength = 8,
    parameter int WorkingRegs  = 4,
    parameter int NBits        = 8,
    parameter int Shift        = 0
) (
    input  logic                                             clk_in,
    input  logic                                             rst_in,
    input  logic                                             vec_ready,
    input  logic signed [WorkingRegs-1:0][NBits-1:0]         vec_in,
    output logic                                             rd_en,
    output logic                                             wrap_rd,
    output logic [$clog2(OutVecLength*InVecLength/WorkingRegs)-1:0] wt_addr,
    input  logic signed [WorkingRegs-1:0][NBits-1:0]         wt_data,
    output logic                                             wr_en,
    output logic signed [NBits-1:0]                          wr_data,
    output logic                                             busy,
    output logic                                             vec_done
);

    localparam int Chunks    = InVecLength / WorkingRegs;
    localparam int AccBits   = acc_bits(NBits, InVecLength);
    localparam int AddrBits  = $clog2(OutVecLength * InVecLength / WorkingRegs);
    localparam int RowBits   = (OutVecLength > 1) ? $clog2(OutVecLength) : 1;
    localparam int ChunkBits = (Chunks > 1) ? $clog2(Chunks) : 1;
    localparam logic [RowBits-1:0]   LastRow   = RowBits'(OutVecLength - 1);
    localparam logic [ChunkBits-1:0] LastChunk = ChunkBits'(Chunks - 1);
    localparam logic EntryRd = (Chunks > 1) || (OutVecLength == 1);

    mvprod_state_t state;
    logic [RowBits-1:0]   row;
    logic [ChunkBits-1:0] chunk;
    logic [1:0]           drain_cnt;
    logic [RowBits-1:0]   nxt_row;
    logic [ChunkBits-1:0] nxt_chunk;
    logic                 nxt_rd;
    logic                 final_issue;

    logic signed [WorkingRegs-1:0][NBits-1:0] chunk_reg;
    logic signed [AccBits-1:0] dot_sum;
    logic signed [AccBits-1:0] acc;
    logic signed [AccBits-1:0] acc_sum;
    logic s1_valid, s1_first, s1_last;
    logic s2_valid, s2_first, s2_last;

    // Position of the next issue; pointer controls are registered one step ahead.
    always_comb begin
        nxt_chunk   = (chunk == LastChunk) ? '0 : chunk + ChunkBits'(1);
        nxt_row     = (chunk == LastChunk) ? row + RowBits'(1) : row;
        final_issue = (chunk == LastChunk) && (row == LastRow);
        nxt_rd      = (nxt_chunk != LastChunk) || (nxt_row == LastRow);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state     <= IDLE;
            row       <= '0;
            chunk     <= '0;
            drain_cnt <= '0;
            wt_addr   <= '0;
            rd_en     <= 1'b0;
            wrap_rd   <= 1'b0;
            busy      <= 1'b0;
            vec_done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (vec_ready) begin
                        state   <= RUN;
                        busy    <= 1'b1;
                        row     <= '0;
                        chunk   <= '0;
                        wt_addr <= '0;
                        rd_en   <= EntryRd;
                        wrap_rd <= !EntryRd;
                    end
                end
                RUN: begin
                    if (final_issue) begin
                        state     <= DRAIN;
                        drain_cnt <= '0;
                        wt_addr   <= '0;
                        rd_en     <= 1'b0;
                        wrap_rd   <= 1'b0;
                    end else begin
                        row     <= nxt_row;
                        chunk   <= nxt_chunk;
                        wt_addr <= wt_addr + AddrBits'(1);
                        rd_en   <= nxt_rd;
                        wrap_rd <= !nxt_rd;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == 2'd2) begin
                        state    <= DONE;
                        vec_done <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 2'd1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    vec_done <= 1'b0;
                    busy     <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    dot_chunk #(
        .WorkingRegs(WorkingRegs),
        .NBits      (NBits),
        .AccBits    (AccBits)
    ) u_dot (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .vec_a (chunk_reg),
        .vec_b (wt_data),
        .sum   (dot_sum)
    );

    assign acc_sum = s2_first ? dot_sum : acc + dot_sum;

    // Issue flags travel alongside the chunk so the accumulator knows when a row starts and ends.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            chunk_reg <= '0;
            s1_valid  <= 1'b0;
            s1_first  <= 1'b0;
            s1_last   <= 1'b0;
            s2_valid  <= 1'b0;
            s2_first  <= 1'b0;
            s2_last   <= 1'b0;
            acc       <= '0;
            wr_en     <= 1'b0;
            wr_data   <= '0;
        end else begin
            if (state == RUN)
                chunk_reg <= vec_in;
            s1_valid <= (state == RUN);
            s1_first <= (chunk == '0);
            s1_last  <= (chunk == LastChunk);
            s2_valid <= s1_valid;
            s2_first <= s1_first;
            s2_last  <= s1_last;
            if (s2_valid)
                acc <= acc_sum;
            wr_en <= s2_valid && s2_last;
            if (s2_valid && s2_last)
                wr_data <= NBits'(sat_shift(SatWidth'(acc_sum), Shift, NBits));
        end
    end

endmodule

// File: tb/tb_mvprod_engine.sv
// Randomised bench: upstream FIFO and weight BRAM models feed two engines (Shift 0 and 2) checked against a plain-arithmetic reference.
module tb_mvprod_engine;

    localparam int InVec  = 4;
    localparam int WR     = 2;
    localparam int OutVec = 2;
    localparam int NB     = 8;
    localparam int Chunks = InVec / WR;
    localparam int N      = OutVec * Chunks;
    localparam int AW     = $clog2(N);

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    logic vec_ready;
    logic signed [WR-1:0][NB-1:0] vec_in;
    logic signed [WR-1:0][NB-1:0] wt_data;

    logic rd_en0, wrap_rd0, wr_en0, busy0, vec_done0;
    logic [AW-1:0] wt_addr0;
    logic signed [NB-1:0] wr_data0;
    logic rd_en2, wrap_rd2, wr_en2, busy2, vec_done2;
    logic [AW-1:0] wt_addr2;
    logic signed [NB-1:0] wr_data2;

    int total = 0;
    int bad = 0;

    logic [NB-1:0] fifo_mem [0:255];
    int rp = 0;
    int vs = 0;
    int wp = 0;
    logic signed [WR-1:0][NB-1:0] wt_mem [0:N-1];
    int wt_val [OutVec][InVec];
    int exp0_q[$];
    int exp2_q[$];
    int gap;
    int waited;
    int rp_start;

    always #5 clk_in = ~clk_in;

    mvprod_engine #(.InVecLength(InVec), .OutVecLength(OutVec), .WorkingRegs(WR), .NBits(NB), .Shift(0)) dut0 (
        .clk_in(clk_in), .rst_in(rst_in), .vec_ready(vec_ready), .vec_in(vec_in),
        .rd_en(rd_en0), .wrap_rd(wrap_rd0), .wt_addr(wt_addr0), .wt_data(wt_data),
        .wr_en(wr_en0), .wr_data(wr_data0), .busy(busy0), .vec_done(vec_done0)
    );

    mvprod_engine #(.InVecLength(InVec), .OutVecLength(OutVec), .WorkingRegs(WR), .NBits(NB), .Shift(2)) dut2 (
        .clk_in(clk_in), .rst_in(rst_in), .vec_ready(vec_ready), .vec_in(vec_in),
        .rd_en(rd_en2), .wrap_rd(wrap_rd2), .wt_addr(wt_addr2), .wt_data(wt_data),
        .wr_en(wr_en2), .wr_data(wr_data2), .busy(busy2), .vec_done(vec_done2)
    );

    // Upstream FIFO: combinational read at the pointer, rewind to the vector start on wrap_rd.
    assign vec_ready = (wp - vs) >= InVec;

    always_comb begin
        for (int i = 0; i < WR; i++)
            vec_in[i] = fifo_mem[rp + i];
    end

    always @(posedge clk_in) begin
        if (rst_in) begin
            rp <= 0;
            vs <= 0;
        end else if (rd_en0) begin
            rp <= rp + WR;
            if (rp + WR - vs == InVec)
                vs <= rp + WR;
        end else if (wrap_rd0) begin
            rp <= vs;
        end
    end

    always @(posedge clk_in)
        wt_data <= wt_mem[wt_addr0];

    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    function automatic int refResult(input int v[4], input int row, input int sh);
        int s;
        s = 0;
        for (int i = 0; i < InVec; i++)
            s += v[i] * wt_val[row][i];
        s = s >>> sh;
        if (s > 127) s = 127;
        if (s < -128) s = -128;
        return s;
    endfunction

    task automatic loadWeights();
        for (int r = 0; r < OutVec; r++)
            for (int c = 0; c < Chunks; c++)
                for (int i = 0; i < WR; i++)
                    wt_mem[r * Chunks + c][i] = NB'(wt_val[r][c * WR + i]);
    endtask

    task automatic randomWeights();
        for (int r = 0; r < OutVec; r++)
            for (int i = 0; i < InVec; i++)
                wt_val[r][i] = int'($urandom_range(255)) - 128;
        loadWeights();
    endtask

    task automatic applyStimulus(input int a, input int b, input int c, input int d);
        int v[4];
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        for (int i = 0; i < InVec; i++)
            fifo_mem[wp + i] = NB'(v[i]);
        wp = wp + InVec;
        for (int r = 0; r < OutVec; r++) begin
            exp0_q.push_back(refResult(v, r, 0));
            exp2_q.push_back(refResult(v, r, 2));
        end
    endtask

    task automatic applyRandom();
        applyStimulus(int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128,
                      int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128);
    endtask

    // Waits for RUN entry, then checks every control output cycle by cycle until the engine is idle again.
    task automatic checkTiming(output int gap_out);
        int exp_rd, exp_wrap, exp_wr, exp_done, exp_busy;
        gap_out = 0;
        while (!busy0 && gap_out < 40) begin
            @(negedge clk_in);
            gap_out++;
        end
        if (!busy0) begin
            checkOutput("busy_timeout", 0, 1);
            return;
        end
        for (int k = 0; k <= N + 4; k++) begin
            if (k > 0) @(negedge clk_in);
            exp_rd = 0;
            exp_wrap = 0;
            if (k < N) begin
                exp_rd = ((k % Chunks) < Chunks - 1 || (k / Chunks) == OutVec - 1) ? 1 : 0;
                exp_wrap = 1 - exp_rd;
                checkOutput($sformatf("wt_addr0@%0d", k), wt_addr0, k);
                checkOutput($sformatf("wt_addr2@%0d", k), wt_addr2, k);
            end
            exp_wr   = (k >= 3 && k - 3 < N && (k - 3) % Chunks == Chunks - 1) ? 1 : 0;
            exp_done = (k == N + 3) ? 1 : 0;
            exp_busy = (k <= N + 3) ? 1 : 0;
            checkOutput($sformatf("rd_en0@%0d", k), rd_en0, exp_rd);
            checkOutput($sformatf("wrap_rd0@%0d", k), wrap_rd0, exp_wrap);
            checkOutput($sformatf("wr_en0@%0d", k), wr_en0, exp_wr);
            checkOutput($sformatf("vec_done0@%0d", k), vec_done0, exp_done);
            checkOutput($sformatf("busy0@%0d", k), busy0, exp_busy);
            checkOutput($sformatf("rd_en2@%0d", k), rd_en2, exp_rd);
            checkOutput($sformatf("wrap_rd2@%0d", k), wrap_rd2, exp_wrap);
            checkOutput($sformatf("wr_en2@%0d", k), wr_en2, exp_wr);
            checkOutput($sformatf("vec_done2@%0d", k), vec_done2, exp_done);
            checkOutput($sformatf("busy2@%0d", k), busy2, exp_busy);
        end
    endtask

    // Result scoreboard: every write must match the next expected element of that engine.
    always @(negedge clk_in) begin
        if (wr_en0) begin
            if (exp0_q.size() == 0)
                checkOutput("wr_extra0", 1, 0);
            else
                checkOutput("wr_data0", wr_data0, exp0_q.pop_front());
        end
        if (wr_en2) begin
            if (exp2_q.size() == 0)
                checkOutput("wr_extra2", 1, 0);
            else
                checkOutput("wr_data2", wr_data2, exp2_q.pop_front());
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_in = 1'b1;
        wp = 0;
        repeat (3) @(negedge clk_in);
        checkOutput("rst_busy", busy0, 0);
        checkOutput("rst_rd_en", rd_en0, 0);
        checkOutput("rst_wrap_rd", wrap_rd0, 0);
        checkOutput("rst_wr_en", wr_en0, 0);
        checkOutput("rst_wr_data", wr_data0, 0);
        checkOutput("rst_vec_done", vec_done0, 0);
        checkOutput("rst_wt_addr", wt_addr0, 0);
        checkOutput("rst_busy2", busy2, 0);
        rst_in = 1'b0;
        @(negedge clk_in);

        $display("[TB] basic product and pointer control");
        wt_val = '{'{1, 1, 1, 1}, '{-1, 0, 0, 2}};
        loadWeights();
        applyStimulus(1, 2, 3, 4);
        checkTiming(gap);
        checkOutput("rd_ptr_basic", rp, 4);

        $display("[TB] saturation");
        wt_val = '{'{127, 127, 127, 127}, '{127, 127, 127, 127}};
        loadWeights();
        applyStimulus(127, 127, 127, 127);
        checkTiming(gap);
        wt_val = '{'{-128, -128, -128, -128}, '{-128, -128, -128, -128}};
        loadWeights();
        applyStimulus(127, 127, 127, 127);
        checkTiming(gap);

        $display("[TB] shift floor behaviour");
        wt_val = '{'{1, 1, 1, 1}, '{-1, -1, -1, -1}};
        loadWeights();
        applyStimulus(1, 2, 3, 4);
        checkTiming(gap);

        $display("[TB] back-to-back vectors");
        rp_start = rp;
        randomWeights();
        applyRandom();
        applyRandom();
        checkTiming(gap);
        checkTiming(gap);
        checkOutput("b2b_gap", gap, 1);
        checkOutput("b2b_rd_ptr", rp - rp_start, 2 * InVec);

        $display("[TB] reset mid-run");
        applyStimulus(5, 6, 7, 8);
        waited = 0;
        while (!busy0 && waited < 40) begin
            @(negedge clk_in);
            waited++;
        end
        checkOutput("mid_busy", busy0, 1);
        @(negedge clk_in);
        rst_in = 1'b1;
        wp = 0;
        exp0_q.delete();
        exp2_q.delete();
        @(negedge clk_in);
        checkOutput("mid_busy_after", busy0, 0);
        checkOutput("mid_rd_en", rd_en0, 0);
        checkOutput("mid_wrap_rd", wrap_rd0, 0);
        checkOutput("mid_wr_data", wr_data0, 0);
        checkOutput("mid_wt_addr", wt_addr0, 0);
        rst_in = 1'b0;
        repeat (8) begin
            @(negedge clk_in);
            checkOutput("mid_no_wr", wr_en0, 0);
            checkOutput("mid_no_done", vec_done0, 0);
        end
        wt_val = '{'{1, 1, 1, 1}, '{-1, 0, 0, 2}};
        loadWeights();
        applyStimulus(1, 2, 3, 4);
        checkTiming(gap);
        checkOutput("mid_rd_ptr", rp, 4);

        $display("[TB] randomised vectors");
        for (int t = 0; t < 8; t++) begin
            randomWeights();
            if ($urandom_range(1) == 1) begin
                applyRandom();
                applyRandom();
                checkTiming(gap);
                checkTiming(gap);
                checkOutput("rand_gap", gap, 1);
            end else begin
                applyRandom();
                checkTiming(gap);
            end
        end

        repeat (5) @(negedge clk_in);
        checkOutput("pending0", exp0_q.size(), 0);
        checkOutput("pending2", exp2_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
